data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words; power of two, 16 to 65536.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state changes on posedge CLK.
REQ-004 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port REQ, input, 1: request strobe.
REQ-006 SHALL have port WE, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port SIZE, input, 3: RISC-V funct3. Encodings: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port ADDR, input, ADDR_W: byte address.
REQ-009 SHALL have port DIN, input, 32: store data, right-aligned.
REQ-010 SHALL have port READY, output, 1: the block accepts a request when REQ and READY are both high at a posedge.
REQ-011 SHALL have port RVALID, output, 1: one-cycle response pulse.
REQ-012 SHALL have port DOUT, output, 32: load result, already extended.
REQ-013 SHALL have port FAULT, output, 2: fault code. 00 ok, 01 misaligned, 10 out of range, 11 illegal SIZE.

Function
REQ-014 SHALL implement a two-state machine: CLEAR and RUN.
REQ-015 In CLEAR, SHALL write zero to word clr_cnt once per cycle, for clr_cnt = 0 to DEPTH-1. SHALL enter RUN on the cycle after word DEPTH-1 is written.
REQ-016 SHALL drive READY=1 only in RUN. REQ in CLEAR SHALL be ignored and SHALL produce no RVALID.
REQ-017 In RUN, SHALL accept one request per cycle; READY SHALL remain high, with no back-pressure.
REQ-018 Every accepted request SHALL produce exactly one RVALID pulse, on the cycle after acceptance (latency 1). Loads and stores both respond.
REQ-019 SHALL check alignment. H/HU require ADDR[0]=0. W requires ADDR[1:0]=00. A violation SHALL give FAULT=01.
REQ-020 SHALL give FAULT=10 when ADDR>>2 >= DEPTH.
REQ-021 SHALL give FAULT=11 when a store uses SIZE not in {000,001,010}, or a load uses SIZE not in {000,001,010,100,101}.
REQ-022 SHALL resolve fault priority as 11 > 01 > 10.
REQ-023 A faulted request SHALL NOT modify memory. Its response SHALL be DOUT=0 with FAULT set.
REQ-024 A valid store SHALL commit on the acceptance edge.
- Byte lanes: B writes lane ADDR[1:0]; H writes lanes ADDR[1]*2 and ADDR[1]*2+1; W writes all four.
- Source data is DIN[7:0] or DIN[15:0].
- Other bytes SHALL be unchanged.
- Response: DOUT=0, FAULT=00.
REQ-025 A valid load SHALL read the word synchronously.
- Select the byte or half by ADDR[1:0].
- B and H sign-extend; BU and HU zero-extend; W passes through.
REQ-026 A load accepted on the cycle after a store to the same word SHALL return the post-store data.
REQ-027 When RVALID=0, DOUT SHALL be 0 and FAULT SHALL be 00.
REQ-028 SHALL use word index ADDR[log2(DEPTH)+1:2]; upper address bits are used only for the range check.

Reset
REQ-029 While RST=1 at a posedge, the block SHALL set:
- state CLEAR, clr_cnt 0
- READY 0, RVALID 0, DOUT 0, FAULT 0
REQ-030 RST asserted mid-operation SHALL drop any pending response, with no RVALID after the reset edge. The zero-fill SHALL restart from word 0.
REQ-031 RST asserted mid-CLEAR SHALL restart the fill from word 0.
REQ-032 The memory array SHALL NOT be zeroed by RST itself. Only the CLEAR sequence zeroes it.

Structure
REQ-033 Package mem_pkg SHALL hold:
- SIZE encodings
- FAULT codes
- the state enum (CLEAR, RUN)
REQ-034 SHALL contain one sub-module, mem_load_align. It is purely combinational and performs lane selection plus sign/zero extension for loads. It has inputs word, ADDR[1:0] and SIZE, and output DOUT.
REQ-035 Storage SHALL be a single DEPTH x 32 array with per-byte write enables.

Verification
REQ-036 The bench SHALL check zero-fill: RST high 2 cycles, then low. Required: READY low for exactly 256 cycles, then high. Load W from 0x3FC returns 0x00000000.
REQ-037 The bench SHALL check store/load by size:
- SW 0x80FF7F01 to 0x10
- LB 0x10 -> 0x00000001
- LB 0x13 -> 0xFFFFFF80
- LBU 0x13 -> 0x00000080
- LH 0x12 -> 0xFFFF80FF
- LHU 0x12 -> 0x000080FF
REQ-038 The bench SHALL check partial writes: SW 0x11223344 to 0x20, then SB 0xAA to 0x21, then LW 0x20. Required: 0x1122AA44. Each request gets RVALID one cycle later.
REQ-039 The bench SHALL check faults:
- LW 0x22 -> FAULT=01
- SW to 0x400 -> FAULT=10, memory unchanged
- load SIZE=011 -> FAULT=11
- SH SIZE=101 to 0x400 -> FAULT=11
REQ-040 The bench SHALL check back-to-back traffic: SW 0xDEADBEEF to 0x8, then LW 0x8 on the next cycle. Required: two consecutive RVALID pulses, the second with DOUT=0xDEADBEEF.
REQ-041 The bench SHALL check reset mid-run: accept LW 0x8, then assert RST on the next edge. Required: no RVALID; READY low for 256 cycles; LW 0x8 afterwards returns 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes (RISC-V funct3),
// fault codes and controller states.
package mem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_SIZE     = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and sign/zero extension; purely combinational.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] dout
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr[1] ? word[31:16] : word[15:0];

    dout = 32'h0;
    case (size)
      SIZE_B:  dout = {{24{lane_b[7]}}, lane_b};
      SIZE_BU: dout = {24'h0, lane_b};
      SIZE_H:  dout = {{16{lane_h[15]}}, lane_h};
      SIZE_HU: dout = {16'h0, lane_h};
      SIZE_W:  dout = word;
      default: dout = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with zero-fill after reset, one request per cycle,
// single-cycle responses and alignment/range/size fault reporting.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [2:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DIN,
  output logic              READY,
  output logic              RVALID,
  output logic [31:0]       DOUT,
  output logic [1:0]        FAULT
);

  localparam int AW = $clog2(DEPTH);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic            accept, do_store;
  logic            size_ok, misaligned, out_of_range;
  logic [1:0]      fault_c;
  logic [3:0]      be;
  logic [31:0]     wdata;

  logic            rvalid_q, load_q;
  logic [1:0]      fault_q, addr_q;
  logic [2:0]      size_q;
  logic [31:0]     rword_q, load_dout;

  assign READY    = (state == ST_RUN);
  assign accept   = REQ && READY && !RST;
  assign idx      = ADDR[AW+1:2];
  assign do_store = accept && WE && (fault_c == FAULT_OK);

  always_comb begin
    case (SIZE)
      SIZE_B, SIZE_H, SIZE_W: size_ok = 1'b1;
      SIZE_BU, SIZE_HU:       size_ok = !WE;
      default:                size_ok = 1'b0;
    endcase
    misaligned   = ((SIZE[1:0] == 2'b01) && ADDR[0]) ||
                   ((SIZE[1:0] == 2'b10) && (ADDR[1:0] != 2'b00));
    out_of_range = (ADDR >> 2) >= ADDR_W'(DEPTH);

    if (!size_ok)         fault_c = FAULT_SIZE;
    else if (misaligned)  fault_c = FAULT_MISALIGN;
    else if (out_of_range) fault_c = FAULT_RANGE;
    else                  fault_c = FAULT_OK;
  end

  always_comb begin
    case (SIZE[1:0])
      2'b00: begin
        be    = 4'b0001 << ADDR[1:0];
        wdata = {4{DIN[7:0]}};
      end
      2'b01: begin
        be    = ADDR[1] ? 4'b1100 : 4'b0011;
        wdata = {2{DIN[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = DIN;
      end
    endcase
  end

  // Storage has no reset: only the CLEAR sequence zeroes it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= 32'h0;
      end else if (do_store) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (accept) rword_q <= mem[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      rvalid_q <= 1'b0;
      load_q   <= 1'b0;
      fault_q  <= FAULT_OK;
      addr_q   <= 2'b00;
      size_q   <= SIZE_B;
    end else begin
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) state <= ST_RUN;
      end
      rvalid_q <= accept;
      if (accept) begin
        fault_q <= fault_c;
        load_q  <= !WE;
        addr_q  <= ADDR[1:0];
        size_q  <= SIZE;
      end
    end
  end

  mem_load_align u_align (
    .word (rword_q),
    .addr (addr_q),
    .size (size_q),
    .dout (load_dout)
  );

  // A reset raised during the response cycle suppresses that response.
  assign RVALID = rvalid_q && !RST;
  assign DOUT   = (RVALID && load_q && (fault_q == FAULT_OK)) ? load_dout : 32'h0;
  assign FAULT  = RVALID ? fault_q : FAULT_OK;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl: a driver queues expected responses,
// a negedge monitor matches every RVALID pulse against them.
module tb_data_mem_ctrl;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  SIZE = 3'b000;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] DIN = 32'h0;
  logic        READY, RVALID;
  logic [31:0] DOUT;
  logic [1:0]  FAULT;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic [1:0]  fault;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  data_mem_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE), .ADDR(ADDR), .DIN(DIN),
    .READY(READY), .RVALID(RVALID), .DOUT(DOUT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every RVALID must match the oldest expectation, in the cycle it is due.
  always @(negedge CLK) begin
    if (RVALID) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: cycle %0d dout=%08h fault=%0b, required no response", cyc, DOUT, FAULT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.due != cyc || DOUT !== e.dout || FAULT !== e.fault) begin
          errors++;
          $display("FAIL %s: cycle %0d dout=%08h fault=%0b, required cycle %0d dout=%08h fault=%0b",
                   e.name, cyc, DOUT, FAULT, e.due, e.dout, e.fault);
        end
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: no RVALID in cycle %0d, required dout=%08h fault=%0b", e.name, cyc, e.dout, e.fault);
      end
      if (DOUT !== 32'h0 || FAULT !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL idle_outputs: cycle %0d dout=%08h fault=%0b, required 0/0", cyc, DOUT, FAULT);
      end
    end
  end

  // Called at posedge+1; leaves the bus idle at the next posedge+1.
  task automatic req(input string name, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] exp_dout, input logic [1:0] exp_fault);
    exp_t e;
    REQ = 1'b1; WE = we; SIZE = size; ADDR = addr; DIN = din;
    e.name = name; e.dout = exp_dout; e.fault = exp_fault; e.due = cyc + 1;
    sb.push_back(e);
    @(posedge CLK); #1;
    REQ = 1'b0;
  endtask

  // Holds RST for two edges, then measures how long READY stays low while
  // a store request is held up during the fill (it must be ignored).
  task automatic reset_fill(input string name);
    int low_cnt = 0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    REQ = 1'b1; WE = 1'b1; SIZE = W; ADDR = 32'h0; DIN = 32'hFFFF_FFFF;
    @(negedge CLK);
    while (!READY && low_cnt < 1000) begin
      low_cnt++;
      @(negedge CLK);
    end
    REQ = 1'b0;
    checks++;
    if (low_cnt != 256 || READY !== 1'b1) begin
      errors++;
      $display("FAIL %s: READY low for %0d cycles then %b, required 256 then 1", name, low_cnt, READY);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    @(posedge CLK); #1;
    checks++;
    if (READY !== 1'b0 || RVALID !== 1'b0 || DOUT !== 32'h0 || FAULT !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: ready=%b rvalid=%b dout=%08h fault=%0b, required 0 0 0 0",
               READY, RVALID, DOUT, FAULT);
    end

    reset_fill("fill_after_reset");
    req("lw_3fc_zero", 1'b0, W, 32'h3FC, 32'h0, 32'h0000_0000, 2'b00);
    req("lw_000_zero", 1'b0, W, 32'h000, 32'h0, 32'h0000_0000, 2'b00);

    req("sw_10",      1'b1, W,  32'h10, 32'h80FF_7F01, 32'h0, 2'b00);
    req("lb_10",      1'b0, B,  32'h10, 32'h0, 32'h0000_0001, 2'b00);
    req("lb_13",      1'b0, B,  32'h13, 32'h0, 32'hFFFF_FF80, 2'b00);
    req("lbu_13",     1'b0, BU, 32'h13, 32'h0, 32'h0000_0080, 2'b00);
    req("lh_12",      1'b0, H,  32'h12, 32'h0, 32'hFFFF_80FF, 2'b00);
    req("lhu_12",     1'b0, HU, 32'h12, 32'h0, 32'h0000_80FF, 2'b00);
    req("lh_10",      1'b0, H,  32'h10, 32'h0, 32'h0000_7F01, 2'b00);
    req("lbu_11",     1'b0, BU, 32'h11, 32'h0, 32'h0000_007F, 2'b00);
    req("lb_12",      1'b0, B,  32'h12, 32'h0, 32'hFFFF_FFFF, 2'b00);

    req("sw_20",      1'b1, W, 32'h20, 32'h1122_3344, 32'h0, 2'b00);
    req("sb_21",      1'b1, B, 32'h21, 32'h0000_00AA, 32'h0, 2'b00);
    req("lw_20_sb",   1'b0, W, 32'h20, 32'h0, 32'h1122_AA44, 2'b00);
    req("sh_22",      1'b1, H, 32'h22, 32'h5555_BEEF, 32'h0, 2'b00);
    req("lw_20_sh",   1'b0, W, 32'h20, 32'h0, 32'hBEEF_AA44, 2'b00);

    req("lw_22_mis",  1'b0, W,      32'h22,  32'h0, 32'h0, 2'b01);
    req("lh_13_mis",  1'b0, H,      32'h13,  32'h0, 32'h0, 2'b01);
    req("sw_400_rng", 1'b1, W,      32'h400, 32'h1234_5678, 32'h0, 2'b10);
    req("lw_0_keep",  1'b0, W,      32'h000, 32'h0, 32'h0000_0000, 2'b00);
    req("ld_sz011",   1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 2'b11);
    req("sh_sz101",   1'b1, HU,     32'h400, 32'h0000_FFFF, 32'h0, 2'b11);
    req("ld_sz011_a", 1'b0, 3'b011, 32'h11,  32'h0, 32'h0, 2'b11);
    req("lw_402_pri", 1'b0, W,      32'h402, 32'h0, 32'h0, 2'b01);
    req("sb_10_sz",   1'b1, BU,     32'h10,  32'h0000_00EE, 32'h0, 2'b11);
    req("lw_10_keep", 1'b0, W,      32'h10,  32'h0, 32'h80FF_7F01, 2'b00);

    req("sw_8",       1'b1, W, 32'h8, 32'hDEAD_BEEF, 32'h0, 2'b00);
    req("lw_8_b2b",   1'b0, W, 32'h8, 32'h0, 32'hDEAD_BEEF, 2'b00);

    // Accept a load, then reset right after: its response must never appear.
    REQ = 1'b1; WE = 1'b0; SIZE = W; ADDR = 32'h8;
    @(posedge CLK); #1;
    REQ = 1'b0;
    reset_fill("fill_after_midrun_reset");
    req("lw_8_cleared", 1'b0, W, 32'h8,  32'h0, 32'h0000_0000, 2'b00);
    req("lw_20_cleared", 1'b0, W, 32'h20, 32'h0, 32'h0000_0000, 2'b00);

    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
